// File: rtl/seven_seg_reader_pkg.sv
// Shared definitions for the seven-segment display reader: segment patterns
// for digits 0..9, the undecodable marker and the capture FSM states.
package seven_seg_reader_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    // Common-cathode patterns, bit6..bit0 = g..a, 1 = segment lit.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    localparam logic [BCD_W-1:0] BCD_BAD = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational decoder from a seven-segment pattern to a BCD digit; any
// pattern outside the ten legal glyphs yields BCD_BAD with o_err set.
module seg_to_bcd
    import seven_seg_reader_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_err
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_bcd = BCD_BAD;
        o_err = 1'b1;
        case (i_seg)
            SEG_0: begin o_bcd = 4'd0; o_err = 1'b0; end
            SEG_1: begin o_bcd = 4'd1; o_err = 1'b0; end
            SEG_2: begin o_bcd = 4'd2; o_err = 1'b0; end
            SEG_3: begin o_bcd = 4'd3; o_err = 1'b0; end
            SEG_4: begin o_bcd = 4'd4; o_err = 1'b0; end
            SEG_5: begin o_bcd = 4'd5; o_err = 1'b0; end
            SEG_6: begin o_bcd = 4'd6; o_err = 1'b0; end
            SEG_7: begin o_bcd = 4'd7; o_err = 1'b0; end
            SEG_8: begin o_bcd = 4'd8; o_err = 1'b0; end
            SEG_9: begin o_bcd = 4'd9; o_err = 1'b0; end
            default: begin
                o_bcd = BCD_BAD;
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Samples a multiplexed seven-segment display bus and captures each digit
// slot once its select/pattern pair has been stable for STABLE_CYCLES cycles.
module seven_seg_reader
    import seven_seg_reader_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_W-1:0]        seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    sel_err
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [SEG_W-1:0]        r_seg;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [BCD_W-1:0]        r_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_err;
    logic                    r_frame_valid;
    logic                    r_sel_err;

    logic                    w_same;
    logic                    w_onehot;
    logic                    w_multi;
    logic                    w_capture;
    logic [NUM_DIGITS-1:0]   w_seen_nxt;
    logic                    w_frame;
    logic [BCD_W-1:0]        w_bcd;
    logic                    w_bad;

    seg_to_bcd u_seg_to_bcd (
        .i_seg (r_seg),
        .o_bcd (w_bcd),
        .o_err (w_bad)
    );

    // A nonzero select with no second bit set is exactly one driven digit.
    assign w_onehot = (dig_en != '0) &&
                      ((dig_en & (dig_en - NUM_DIGITS'(1))) == '0);
    assign w_multi  = (dig_en != '0) && !w_onehot;
    assign w_same   = (dig_en == r_en) && (seg == r_seg);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_onehot) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            SETTLE, HOLD: begin
                if (!w_same) begin
                    if (w_onehot) begin
                        w_state_nxt = SETTLE;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (r_state == SETTLE) begin
                    if (r_cnt == CNT_LAST) begin
                        w_capture   = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The registered pair equals the live pair on a capture edge, so r_en
    // names the slot and the decoder already sees the captured pattern.
    assign w_seen_nxt = r_seen | (w_capture ? r_en : '0);
    assign w_frame    = w_capture && (w_seen_nxt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_en          <= '0;
            r_seg         <= '0;
            r_seen        <= '0;
            r_frame_valid <= 1'b0;
            r_sel_err     <= 1'b0;
            r_err         <= '1;
            // NOTE: the slot array is tiny and its reset value is observable, so it is reset like any other flop.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digits[i] <= BCD_BAD;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_en          <= dig_en;
            r_seg         <= seg;
            r_seen        <= w_frame ? '0 : w_seen_nxt;
            r_frame_valid <= w_frame;
            r_sel_err     <= w_multi;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && r_en[i]) begin
                    r_digits[i] <= w_bcd;
                    r_err[i]    <= w_bad;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
        assign digits[4*g +: 4] = r_digits[g];
    end

    assign digit_err   = r_err;
    assign frame_valid = r_frame_valid;
    assign sel_err     = r_sel_err;

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of multiplexed digit positions monitored (valid range 1..8).
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical input cycles required before capture (valid range 2..255).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 seg  input  7  segment bus, bit6..bit0 = g..a, active-high (common cathode; 1 = segment lit).
REQ-006 dig_en  input  NUM_DIGITS  digit select, active-high, one-hot when a digit is driven; bit i selects slot i.
REQ-007 digits  output  4*NUM_DIGITS  captured values, slot i at bits [4i+3:4i], binary 0..9, 4'hF = undecodable.
REQ-008 digit_err  output  NUM_DIGITS  bit i high while slot i holds an undecodable pattern.
REQ-009 frame_valid  output  1  one-cycle pulse: every slot captured at least once since the previous pulse or reset.
REQ-010 sel_err  output  1  one-cycle pulse: dig_en multi-hot this cycle.

Function
REQ-011 Decode table: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F; any other pattern (incl. 7'h00) is undecodable -> 4'hF and err=1.
REQ-012 Input pair (dig_en, seg) is registered each cycle; "unchanged" = current pair equals previous cycle's registered pair.
REQ-013 FSM states IDLE, SETTLE, HOLD; stable counter cnt, width ceil(log2(STABLE_CYCLES+1)).
REQ-014 IDLE: dig_en one-hot -> SETTLE, cnt=1; otherwise stay IDLE.
REQ-015 SETTLE: unchanged and cnt<STABLE_CYCLES-1 -> cnt+1; unchanged and cnt==STABLE_CYCLES-1 -> capture, HOLD.
REQ-016 SETTLE/HOLD: changed pair with new dig_en one-hot -> SETTLE, cnt=1; changed with dig_en zero or multi-hot -> IDLE, cnt=0.
REQ-017 HOLD: unchanged -> stay HOLD, no further capture (exactly one capture per stable interval).
REQ-018 Capture latency: digits/digit_err for the selected slot update on the edge ending the STABLE_CYCLES-th consecutive identical cycle; visible the next cycle.
REQ-019 Capture sets slot's bit in internal seen mask; when the capture completes the mask, frame_valid pulses the same cycle the last slot updates and the mask clears to 0 on that edge.
REQ-020 Recapture of an already-seen slot overwrites its value; mask unchanged.
REQ-021 dig_en multi-hot: sel_err pulses the following cycle; no capture; treated as blanking (REQ-016).
REQ-022 Blanking (dig_en=0) between digits is legal; never clears digits or mask.
REQ-023 Unselected slots retain value indefinitely.

Reset
REQ-024 rst high: state=IDLE, cnt=0, registered pair=0, seen mask=0, digits=all 4'hF, digit_err=all 1, frame_valid=0, sel_err=0, from the next cycle.
REQ-025 rst mid-SETTLE discards partial count; no capture occurs on the reset edge.
REQ-026 First capture after reset requires a full STABLE_CYCLES interval starting after rst deasserts.

Structure
REQ-027 Shared package holds the segment pattern constants (SEG_0..SEG_9), the undecodable code 4'hF and the FSM state enum.
REQ-028 One combinational sub-module seg_to_bcd (7-bit pattern -> 4-bit value + err flag) instantiated once, fed from the registered seg.

Verification
REQ-029 After reset, hold dig_en=2'b01, seg=7'h5B for 4 cycles -> digits[3:0]=2, digit_err[0]=0, frame_valid=0; hold 10 more cycles -> no further update.
REQ-030 Slot0 7'h6D x4, blank x2, slot1 7'h06 x4 -> digits=8'h15, frame_valid single pulse with slot1 update, digit_err=2'b00.
REQ-031 dig_en=2'b01, seg=7'h5B for 3 cycles then seg=7'h4F for 4 -> digits[3:0]=3, value 2 never captured.
REQ-032 dig_en=2'b11 for 6 cycles -> sel_err pulse, no capture, digits unchanged.
REQ-033 Slot1 seg=7'h49 for 4 cycles -> digits[7:4]=4'hF, digit_err[1]=1; then 7'h7F x4 -> 8, digit_err[1]=0.
REQ-034 rst asserted on cycle 3 of a 4-cycle stable interval -> no capture, outputs at reset values; capture only after 4 new stable cycles.
